hex_disp_mux: RTL and testbench
===============================

Name: hex_disp_mux

Overview:
- Time-multiplexed 4-digit seven-segment driver. It consumes the two 8-bit event counts from the debounce counter: raw count on digits 3..2, debounced count on digits 1..0.
- Scans one digit per slot and decodes hex to active-low segments.
- Optional leading-zero suppression, plus a per-slot anti-ghosting blank interval.
- All outputs are registered, so pin drive is glitch-free.

Parameters:
- N, 18, refresh counter width. Slot length = 2^(N-2) clocks. Full scan = 2^N clocks.
- BLANK_CYC, 64, clocks at the start of each slot with all anodes off. Legal range 0 .. 2^(N-2)-1.

Ports:
- i_clk  input  1  system clock
- i_rst  input  1  asynchronous, active-high reset
- i_hex3  input  4  digit 3 value (leftmost)
- i_hex2  input  4  digit 2 value
- i_hex1  input  4  digit 1 value
- i_hex0  input  4  digit 0 value (rightmost)
- i_dp_n  input  4  decimal points, active low; bit k belongs to digit k
- i_lz_en  input  1  1 = leading-zero suppression enabled
- o_an  output  4  anodes, active low; bit k = digit k
- o_sseg  output  8  {dp,g,f,e,d,c,b,a}, all active low
- o_slot  output  2  index of the digit currently scanned (debug)

Behaviour:
- Reset is async and active-high. While i_rst is high or after it is asserted:
  - r_cnt = 0
  - o_an = 4'b1111
  - o_sseg = 8'hFF
  - o_slot = 0
- Refresh counter r_cnt (N bits):
  - Free-running, +1 per clock, wraps from 2^N-1 to 0 with no stall.
  - Slot index s = r_cnt[N-1:N-2]. Scan order is 0,1,2,3,0,...
  - Offset within the slot: off = r_cnt[N-3:0].
- Output registers, updated every clock from the current r_cnt and the current inputs. Latency is 1 clock from counter/input to pins:
  - o_slot <= s
  - o_an <= 4'b1111 if off < BLANK_CYC; otherwise ~(4'b0001 << s)
  - o_sseg[6:0] <= decode(hex_s), or 7'h7F if digit s is suppressed
  - o_sseg[7] <= i_dp_n[s]. The dp is not affected by suppression.
- Decode table (o_sseg with dp off):
  - 0:C0, 1:F9, 2:A4, 3:B0, 4:99, 5:92, 6:82, 7:F8
  - 8:80, 9:90, A:88, b:83, C:C6, d:A1, E:86, F:8E
- Leading-zero suppression, active only when i_lz_en = 1:
  - Digit 3 is suppressed if hex3 = 0.
  - Digit 2 is suppressed if hex3 = 0 and hex2 = 0.
  - Digit 1 is suppressed if hex3, hex2 and hex1 are all 0.
  - Digit 0 is never suppressed, so value 0 shows a single "0".
  - Suppression is evaluated across all 4 digits, not per byte.
- Input changes mid-slot take effect on the next clock edge. There is no slot-boundary holding.
- BLANK_CYC = 0: no blank interval; the anode is active for the entire slot.
- Reset asserted mid-slot: outputs go to reset values immediately, with no clock required. After release, scanning restarts at slot 0, offset 0, and the blank interval applies first.
- No combinational path from any input to any output.

Test Plan (N=4, BLANK_CYC=1, slot = 4 clocks):
1. Reset and first slot:
   - Stimulus: assert i_rst asynchronously between clock edges.
   - Response: o_an=1111, o_sseg=FF immediately.
   - Then release with hex3..0=1,2,3,4, i_dp_n=1111, i_lz_en=0.
   - Response: first post-release edge gives o_an=1111 (blank). Edges 2-4 give o_an=1110, o_sseg=99.
2. Full scan:
   - Stimulus: continue running.
   - Response: per-slot outputs are o_an=1101/sseg=B0, 1011/A4, 0111/F9, then back to 1110/99.
   - Each slot shows exactly 1 blank clock then 3 active clocks. Full period = 16 clocks; verify across 3 wraps.
3. Decode sweep:
   - Stimulus: drive hex0 through 0..F, holding each value one full scan.
   - Response: slot-0 o_sseg matches every table entry.
4. Leading-zero suppression:
   - Stimulus: i_lz_en=1, hex=0,0,0,7.
   - Response: digits 3..1 give o_sseg=FF with anodes still cycling; digit 0 gives F8.
   - Stimulus: hex=0,5,0,0.
   - Response: digit 3 gives FF; digits 2..0 give 92,C0,C0.
   - Stimulus: all zero.
   - Response: only digit 0 shows C0.
5. Decimal point:
   - Stimulus: i_dp_n=1011 with lz_en=1 and hex=0,0,0,0.
   - Response: digit 2 gives o_sseg=7F (suppressed digit, dp lit). Others give FF, except digit 0 which gives C0.
6. Reset mid-slot:
   - Stimulus: assert i_rst at slot 2, offset 2.
   - Response: o_an=1111 and o_slot=0 at once. After release, the scan restarts with slot 0's blank clock.

Source files
------------

// File: rtl/hex_disp_mux.sv
// rtl/hex_disp_mux.sv - time-multiplexed 4-digit seven-segment driver
//
// Scans one digit per slot from a free-running refresh counter, decodes the
// selected hex nibble to active-low segments and drives active-low anodes.
// Each slot begins with BLANK_CYC clocks of all-anodes-off so that the previous
// digit's segments never ghost onto the next digit. Every output is a flop.
//
// Ports:
//   i_clk     system clock
//   i_rst     asynchronous, active-high reset
//   i_hex3..0 digit values, digit 3 leftmost
//   i_dp_n    decimal points, active low, bit k = digit k
//   i_lz_en   1 = blank leading zeros on digits 3..1
//   o_an      anodes, active low, bit k = digit k
//   o_sseg    {dp,g,f,e,d,c,b,a}, active low
//   o_slot    index of the digit currently scanned
module hex_disp_mux #(
  parameter int N         = 18,
  parameter int BLANK_CYC = 64
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [3:0] i_hex3,
  input  logic [3:0] i_hex2,
  input  logic [3:0] i_hex1,
  input  logic [3:0] i_hex0,
  input  logic [3:0] i_dp_n,
  input  logic       i_lz_en,
  output logic [3:0] o_an,
  output logic [7:0] o_sseg,
  output logic [1:0] o_slot
);

  localparam logic [N-3:0] BLANK_OFF = (N-2)'(BLANK_CYC);
  localparam logic [N-1:0] CNT_ONE   = N'(1);

  logic [N-1:0] cnt_q, cnt_d;
  logic [3:0]   an_q, an_d;
  logic [7:0]   sseg_q, sseg_d;
  logic [1:0]   slot_q, slot_d;

  logic [1:0]   slot;
  logic [N-3:0] off;
  logic [3:0]   hex_sel;
  logic         sup_sel;
  logic         sup3, sup2, sup1;

  // Segment pattern {g,f,e,d,c,b,a}, active low.
  function automatic logic [6:0] decode(input logic [3:0] hex);
    logic [6:0] seg;
    case (hex)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      default: seg = 7'h0E;
    endcase
    return seg;
  endfunction

  always_comb begin
    cnt_d = cnt_q + CNT_ONE;
    slot  = cnt_q[N-1:N-2];
    off   = cnt_q[N-3:0];

    // Suppression chains from the leftmost digit across the whole 16-bit
    // value; digit 0 always shows so a zero value still displays "0".
    sup3 = i_lz_en && (i_hex3 == 4'h0);
    sup2 = sup3 && (i_hex2 == 4'h0);
    sup1 = sup2 && (i_hex1 == 4'h0);

    hex_sel = i_hex0;
    sup_sel = 1'b0;
    case (slot)
      2'd0: begin hex_sel = i_hex0; sup_sel = 1'b0; end
      2'd1: begin hex_sel = i_hex1; sup_sel = sup1; end
      2'd2: begin hex_sel = i_hex2; sup_sel = sup2; end
      default: begin hex_sel = i_hex3; sup_sel = sup3; end
    endcase

    slot_d = slot;
    an_d   = (off < BLANK_OFF) ? 4'b1111 : ~(4'b0001 << slot);
    // The decimal point ignores suppression.
    sseg_d = {i_dp_n[slot], (sup_sel ? 7'h7F : decode(hex_sel))};
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt_q  <= '0;
      an_q   <= 4'b1111;
      sseg_q <= 8'hFF;
      slot_q <= 2'd0;
    end else begin
      cnt_q  <= cnt_d;
      an_q   <= an_d;
      sseg_q <= sseg_d;
      slot_q <= slot_d;
    end
  end

  assign o_an   = an_q;
  assign o_sseg = sseg_q;
  assign o_slot = slot_q;

endmodule

// File: tb/tb_hex_disp_mux.sv
// tb/tb_hex_disp_mux.sv - self-checking bench for hex_disp_mux
module tb_hex_disp_mux;

  localparam int N         = 4;
  localparam int BLANK_CYC = 1;
  localparam int SLOT_LEN  = 1 << (N - 2);
  localparam int SCAN_LEN  = 1 << N;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] hex3 = 4'h0, hex2 = 4'h0, hex1 = 4'h0, hex0 = 4'h0;
  logic [3:0] dp_n = 4'hF;
  logic       lz_en = 1'b0;
  logic [3:0] an;
  logic [7:0] sseg;
  logic [1:0] slot;

  int passed = 0;
  int failed = 0;
  int edges  = 0;

  byte unsigned seg_tbl [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                 8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  hex_disp_mux #(.N(N), .BLANK_CYC(BLANK_CYC)) dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .i_hex3 (hex3),
    .i_hex2 (hex2),
    .i_hex1 (hex1),
    .i_hex0 (hex0),
    .i_dp_n (dp_n),
    .i_lz_en(lz_en),
    .o_an   (an),
    .o_sseg (sseg),
    .o_slot (slot)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s edge=%0d observed=%h expected=%h", tag, edges, obs, exp);
    end
  endtask

  // Reference: after the k-th clock since reset release the pins reflect the
  // counter value k-1, i.e. position (k-1) mod 16 within the scan.
  task automatic check_model();
    int cyc, s, off, value, digit;
    logic [3:0] exp_an;
    logic [7:0] exp_sseg;
    logic [7:0] pat;
    bit supp;
    cyc   = (edges - 1) % SCAN_LEN;
    s     = cyc / SLOT_LEN;
    off   = cyc % SLOT_LEN;
    value = {16'h0, hex3, hex2, hex1, hex0};
    digit = (value >> (4 * s)) & 15;
    supp  = lz_en && (s != 0) && ((value >> (4 * s)) == 0);
    exp_an = (off < BLANK_CYC) ? 4'hF : (4'hF & ~(4'(1) << s));
    pat = seg_tbl[digit];
    exp_sseg = {dp_n[s], (supp ? 7'h7F : pat[6:0])};
    check("an", 32'(an), 32'(exp_an));
    check("sseg", 32'(sseg), 32'(exp_sseg));
    check("slot", 32'(slot), 32'(s));
  endtask

  task automatic step();
    @(posedge clk);
    edges++;
    #1;
    check_model();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic set_hex(input logic [3:0] a, input logic [3:0] b,
                         input logic [3:0] c, input logic [3:0] d);
    hex3 = a; hex2 = b; hex1 = c; hex0 = d;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_an"}, 32'(an), 32'h0000_000F);
    check({tag, "_sseg"}, 32'(sseg), 32'h0000_00FF);
    check({tag, "_slot"}, 32'(slot), 32'h0);
  endtask

  initial begin
    // Reset held from time zero.
    repeat (2) @(posedge clk);
    #1;
    check_reset_vals("rst_init");

    // Release, run a bit, then assert reset between edges.
    #4 rst = 1'b0;
    edges = 0;
    set_hex(4'h9, 4'h8, 4'h7, 4'h6);
    run(6);
    #2 rst = 1'b1;
    #1 check_reset_vals("rst_async");

    // First slot and full scan over three wraps.
    set_hex(4'h1, 4'h2, 4'h3, 4'h4);
    dp_n = 4'hF; lz_en = 1'b0;
    #2 rst = 1'b0;
    edges = 0;
    step();
    check("first_blank", 32'(an), 32'h0000_000F);
    run(3);
    check("first_digit", 32'(sseg), 32'h0000_0099);
    run(3 * SCAN_LEN - 4);

    // Decode sweep on digit 0.
    for (int v = 0; v < 16; v++) begin
      hex0 = 4'(v);
      run(SCAN_LEN);
    end

    // Leading-zero suppression.
    lz_en = 1'b1;
    set_hex(4'h0, 4'h0, 4'h0, 4'h7);
    run(SCAN_LEN);
    set_hex(4'h0, 4'h5, 4'h0, 4'h0);
    run(SCAN_LEN);
    set_hex(4'h0, 4'h0, 4'h0, 4'h0);
    run(SCAN_LEN);

    // Decimal point on a suppressed digit.
    dp_n = 4'b1011;
    run(SCAN_LEN);

    // Zero blank clocks are not exercised here; randomized inputs changing
    // at arbitrary points mid-slot.
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        hex3  = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
        hex2  = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
        hex1  = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
        hex0  = 4'($urandom_range(0, 15));
        dp_n  = 4'($urandom_range(0, 15));
        lz_en = 1'($urandom_range(0, 1));
      end
      step();
    end

    // Reset mid-slot: counter at slot 2, offset 2.
    while ((edges % SCAN_LEN) != 10) step();
    #2 rst = 1'b1;
    #1 check_reset_vals("rst_mid");
    #2 rst = 1'b0;
    edges = 0;
    step();
    check("restart_blank", 32'(an), 32'h0000_000F);
    run(SCAN_LEN);

    $display("%0d/%0d checks passed", passed, passed + failed);
    $finish;
  end

endmodule
